tag_ram_ctrl: RTL and testbench
===============================

// Module: tag_ram_ctrl
// PURPOSE
//  Sequencing controller for one synchronous-read cache tag RAM bank. Each entry is {valid, tag}.
//  Clears every entry after reset, then serves one requester at a time.
//  Services tag lookups (hit/miss plus victim tag) and fills (write {1,tag}).
//  Sits between the cache control FSM and the tag RAM bank, and owns all RAM address and write-enable traffic.
// PARAMETERS
//  AWIDTH  3  index width; DEPTH = 1<<AWIDTH entries
//  DWIDTH  9  RAM word width; bit DWIDTH-1 = valid, bits DWIDTH-2:0 = tag (TAG_W = DWIDTH-1)
// PORTS
//  clock          in   1        single clock; all state changes on posedge
//  reset_n        in   1        synchronous, active-low reset
//  req_valid      in   1        request present
//  req_ready      out  1        request accepted on posedge when req_valid & req_ready
//  req_fill       in   1        1 = fill (write tag), 0 = lookup
//  req_index      in   AWIDTH   set index
//  req_tag        in   TAG_W    tag to compare or write
//  rsp_valid      out  1        one-cycle response pulse (no backpressure)
//  rsp_hit        out  1        lookup hit (always 0 for fills)
//  rsp_vic_valid  out  1        valid bit of the entry read by the lookup
//  rsp_vic_tag    out  TAG_W    tag field of the entry read by the lookup
//  init_done      out  1        1 once the post-reset clear sweep has finished
//  ram_addr       out  AWIDTH   to RAM addr; RAM latches it on posedge
//  ram_din        out  DWIDTH   to RAM din
//  ram_we         out  1        to RAM we
//  ram_dout       in   DWIDTH   from RAM; valid in the cycle after the address is latched
// BEHAVIOUR
//  States: INIT, IDLE, RD, CMP, WR.
//  Reset (reset_n=0 at posedge):
//   - state=INIT, sweep counter=0.
//   - rsp_valid=0, rsp_hit=0, rsp_vic_valid=0, rsp_vic_tag=0, init_done=0.
//   - Any in-flight request is dropped with no response.
//  INIT:
//   - Drives ram_we=1, ram_din=0, ram_addr=counter; counter increments every cycle.
//   - After the DEPTH-1 write: state->IDLE, init_done=1 (stays 1 until the next reset).
//   - Sweep takes exactly DEPTH cycles.
//  IDLE:
//   - req_ready=1; it is 0 in every other state.
//   - On accept, capture req_index, req_tag and req_fill.
//   - Lookup -> RD; fill -> WR.
//  RD:
//   - ram_addr=idx_q, ram_we=0; RAM latches the address. -> CMP.
//  CMP:
//   - hit = ram_dout[DWIDTH-1] & (ram_dout[TAG_W-1:0]==tag_q).
//   - Registers rsp_hit=hit, rsp_vic_valid=ram_dout[MSB], rsp_vic_tag=ram_dout[TAG_W-1:0], rsp_valid=1.
//   - -> IDLE.
//  WR:
//   - ram_addr=idx_q, ram_we=1, ram_din={1'b1,tag_q}.
//   - Registers rsp_valid=1, rsp_hit=0; rsp_vic_* hold their previous values.
//   - -> IDLE.
//  Latency:
//   - Lookup accepted at edge k: rsp_valid high in the cycle after edge k+2.
//   - Fill accepted at edge k: rsp_valid high in the cycle after edge k+1.
//   - Throughput: next accept at edge k+3 (lookup) or k+2 (fill).
//   - req_ready is already 1 in the cycle rsp_valid is high.
//  rsp_valid is high for exactly one cycle per accepted request. rsp_hit/vic fields are stable while it is high.
//  ram_we=0 in IDLE, RD and CMP.
//  ram_addr holds its last value whenever it is not being driven by the current state.
//  Fill followed by a lookup of the same index returns the new tag: the write lands before the read address is latched.
//  req_valid while init_done=0 is ignored; no accept.
//  Index wrap: the sweep counter is AWIDTH+1 bits wide, or terminal-detected, so the INIT->IDLE exit is unambiguous for any AWIDTH.
// TESTING
//  T1 reset_n low 2 cycles, then high -> ram_we=1 for 8 cycles with addr 0..7 and din 0. init_done rises after the 8th write. req_ready=0 throughout.
//  T2 after init, lookup idx=3 tag=0x5A -> 3 cycles later: rsp_valid=1, hit=0, vic_valid=0, vic_tag=0x00.
//  T3 fill idx=3 tag=0x5A -> RAM write addr=3 din=9'h15A, rsp_valid 2 cycles later. Then lookup idx=3 tag=0x5A -> hit=1, vic_tag=0x5A.
//  T4 lookup idx=3 tag=0x5B -> hit=0, vic_valid=1, vic_tag=0x5A. Lookup idx=4 tag=0x5A -> hit=0, vic_valid=0.
//  T5 req_valid held high with alternating lookup/fill, random idx/tag -> accepts spaced 3/2 cycles apart; responses match a scoreboard model; never two rsp per accept.
//  T6 reset_n low during CMP of a pending lookup -> no rsp_valid, init sweep restarts at addr 0, a previously filled entry reads as a miss afterwards.

Source files
------------

// File: rtl/tag_ram_ctrl.sv
// Sequencing controller for one synchronous-read cache tag RAM bank.
// Clears the bank after reset, then serves one lookup or fill at a time.
module tag_ram_ctrl #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 9
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_fill,
  input  logic [AWIDTH-1:0] req_index,
  input  logic [DWIDTH-2:0] req_tag,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic              rsp_vic_valid,
  output logic [DWIDTH-2:0] rsp_vic_tag,
  output logic              init_done,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  localparam int TAG_W = DWIDTH - 1;
  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] CNT_LAST = (AWIDTH + 1)'(DEPTH - 1);

  typedef enum logic [2:0] {INIT, IDLE, RD, CMP, WR} state_t;

  state_t            state_q;
  logic [AWIDTH:0]   cnt_q;
  logic [AWIDTH-1:0] idx_q;
  logic [TAG_W-1:0]  tag_q;
  logic [AWIDTH-1:0] addr_hold_q;
  logic              rsp_valid_q;
  logic              rsp_hit_q;
  logic              rsp_vic_valid_q;
  logic [TAG_W-1:0]  rsp_vic_tag_q;
  logic              init_done_q;
  logic              hit_d;

  assign hit_d = ram_dout[DWIDTH-1] & (ram_dout[TAG_W-1:0] == tag_q);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= INIT;
      cnt_q           <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_vic_valid_q <= 1'b0;
      rsp_vic_tag_q   <= '0;
      init_done_q     <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + (AWIDTH + 1)'(1);
          if (cnt_q == CNT_LAST) begin
            state_q     <= IDLE;
            init_done_q <= 1'b1;
          end
        end
        IDLE: begin
          if (req_valid) begin
            idx_q   <= req_index;
            tag_q   <= req_tag;
            state_q <= req_fill ? WR : RD;
          end
        end
        RD: state_q <= CMP;
        CMP: begin
          rsp_valid_q     <= 1'b1;
          rsp_hit_q       <= hit_d;
          rsp_vic_valid_q <= ram_dout[DWIDTH-1];
          rsp_vic_tag_q   <= ram_dout[TAG_W-1:0];
          state_q         <= IDLE;
        end
        WR: begin
          rsp_valid_q <= 1'b1;
          rsp_hit_q   <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // RAM address is only steered in INIT/RD/WR; elsewhere it repeats the last value driven.
  always_ff @(posedge clock) begin
    addr_hold_q <= ram_addr;
  end

  always_comb begin
    ram_addr = addr_hold_q;
    ram_din  = '0;
    ram_we   = 1'b0;
    case (state_q)
      INIT: begin
        ram_addr = cnt_q[AWIDTH-1:0];
        ram_we   = 1'b1;
      end
      RD: ram_addr = idx_q;
      WR: begin
        ram_addr = idx_q;
        ram_din  = {1'b1, tag_q};
        ram_we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ready     = (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_hit       = rsp_hit_q;
  assign rsp_vic_valid = rsp_vic_valid_q;
  assign rsp_vic_tag   = rsp_vic_tag_q;
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Directed bench for tag_ram_ctrl with a behavioural synchronous-read RAM
// and a small scoreboard for back-to-back traffic.
module tb_tag_ram_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_fill;
  logic [2:0] req_index;
  logic [7:0] req_tag;
  logic       rsp_valid;
  logic       rsp_hit;
  logic       rsp_vic_valid;
  logic [7:0] rsp_vic_tag;
  logic       init_done;
  logic [2:0] ram_addr;
  logic [8:0] ram_din;
  logic       ram_we;
  logic [8:0] ram_dout;

  logic [8:0] mem [8];
  logic       preload;
  int         errors = 0;
  int         checks = 0;

  tag_ram_ctrl #(.AWIDTH(3), .DWIDTH(9)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_fill(req_fill),
    .req_index(req_index), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .rsp_vic_valid(rsp_vic_valid), .rsp_vic_tag(rsp_vic_tag),
    .init_done(init_done),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clock = ~clock;

  // Read-first synchronous RAM; the preload fills it with junk so the clear sweep is visible.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 8; i++) mem[i] <= 9'h1AA;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Presents one request at a negedge; returns at the negedge just after it is accepted.
  task automatic applyStimulus(input logic fill, input logic [2:0] idx, input logic [7:0] tag);
    int n;
    req_valid = 1'b1;
    req_fill  = fill;
    req_index = idx;
    req_tag   = tag;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic expectResponse(input string name, input int lat, input logic hit,
                                input logic vv, input logic [7:0] vt);
    int n;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clock);
      n++;
    end
    checkOutput({name, "_latency"}, 32'(n), 32'(lat));
    checkOutput({name, "_hit"}, 32'(rsp_hit), 32'(hit));
    checkOutput({name, "_vic_valid"}, 32'(rsp_vic_valid), 32'(vv));
    checkOutput({name, "_vic_tag"}, 32'(rsp_vic_tag), 32'(vt));
    checkOutput({name, "_ready_with_rsp"}, 32'(req_ready), 32'd1);
    @(negedge clock);
    checkOutput({name, "_pulse_end"}, 32'(rsp_valid), 32'd0);
  endtask

  // Called at the first negedge of INIT: expects the DEPTH-cycle clear sweep.
  task automatic sweepCheck(input string name);
    for (int i = 0; i < 8; i++) begin
      checkOutput({name, "_we"}, 32'(ram_we), 32'd1);
      checkOutput({name, "_addr"}, 32'(ram_addr), 32'(i));
      checkOutput({name, "_din"}, 32'(ram_din), 32'd0);
      checkOutput({name, "_ready"}, 32'(req_ready), 32'd0);
      checkOutput({name, "_init_done"}, 32'(init_done), 32'd0);
      checkOutput({name, "_no_rsp"}, 32'(rsp_valid), 32'd0);
      if (i == 7) req_valid = 1'b0;
      @(negedge clock);
    end
    checkOutput({name, "_done"}, 32'(init_done), 32'd1);
    checkOutput({name, "_idle_we"}, 32'(ram_we), 32'd0);
    checkOutput({name, "_idle_ready"}, 32'(req_ready), 32'd1);
    for (int i = 0; i < 8; i++) checkOutput({name, "_mem_clear"}, 32'(mem[i]), 32'd0);
  endtask

  // Scoreboard state for back-to-back traffic
  logic [8:0] model [8];
  logic       expHit [$];
  logic       expVv [$];
  logic [7:0] expVt [$];

  initial begin
    logic       lastVv;
    logic [7:0] lastVt;
    logic       fills [12];
    logic [2:0] idxs [12];
    logic [7:0] tags [12];
    int         k;
    int         cyc;
    int         lastAcc;
    logic       lastFill;

    preload   = 1'b1;
    reset_n   = 1'b0;
    req_valid = 1'b1;
    req_fill  = 1'b1;
    req_index = 3'd5;
    req_tag   = 8'h77;
    @(negedge clock);
    preload = 1'b0;
    $display("[TB] T1 reset and clear sweep");
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_hit", 32'(rsp_hit), 32'd0);
    checkOutput("reset_vic_valid", 32'(rsp_vic_valid), 32'd0);
    checkOutput("reset_vic_tag", 32'(rsp_vic_tag), 32'd0);
    checkOutput("reset_init_done", 32'(init_done), 32'd0);
    checkOutput("reset_ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    sweepCheck("t1_sweep");

    $display("[TB] T2 lookup of cleared entry");
    applyStimulus(1'b0, 3'd3, 8'h5A);
    checkOutput("t2_rd_we", 32'(ram_we), 32'd0);
    checkOutput("t2_rd_addr", 32'(ram_addr), 32'd3);
    checkOutput("t2_rd_ready", 32'(req_ready), 32'd0);
    expectResponse("t2", 2, 1'b0, 1'b0, 8'h00);
    checkOutput("t2_addr_hold", 32'(ram_addr), 32'd3);

    $display("[TB] T3 fill then hit");
    applyStimulus(1'b1, 3'd3, 8'h5A);
    checkOutput("t3_wr_we", 32'(ram_we), 32'd1);
    checkOutput("t3_wr_addr", 32'(ram_addr), 32'd3);
    checkOutput("t3_wr_din", 32'(ram_din), 32'h15A);
    expectResponse("t3_fill", 1, 1'b0, 1'b0, 8'h00);
    checkOutput("t3_idle_we", 32'(ram_we), 32'd0);
    applyStimulus(1'b0, 3'd3, 8'h5A);
    expectResponse("t3_lookup", 2, 1'b1, 1'b1, 8'h5A);

    $display("[TB] T4 tag mismatch and empty set");
    applyStimulus(1'b0, 3'd3, 8'h5B);
    expectResponse("t4_mismatch", 2, 1'b0, 1'b1, 8'h5A);
    applyStimulus(1'b0, 3'd4, 8'h5A);
    expectResponse("t4_empty", 2, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 3'd6, 8'hC3);
    expectResponse("t4_fill_holds_vic", 1, 1'b0, 1'b0, 8'h00);

    $display("[TB] T5 back-to-back traffic");
    for (int i = 0; i < 8; i++) model[i] = 9'h000;
    model[3] = 9'h15A;
    model[6] = 9'h1C3;
    lastVv = 1'b0;
    lastVt = 8'h00;
    for (int i = 0; i < 12; i++) begin
      fills[i] = i[0];
      idxs[i]  = (i % 4 == 2) ? idxs[i-1] : 3'($urandom_range(0, 7));
      tags[i]  = (i % 4 == 2) ? tags[i-1] : 8'($urandom_range(0, 255));
    end
    k = 0;
    cyc = 0;
    lastAcc = 0;
    lastFill = 1'b0;
    while ((k < 12 || expHit.size() != 0) && cyc < 300) begin
      if (rsp_valid) begin
        if (expHit.size() == 0) begin
          checkOutput("t5_spurious_rsp", 32'd1, 32'd0);
        end else begin
          checkOutput("t5_hit", 32'(rsp_hit), 32'(expHit.pop_front()));
          checkOutput("t5_vic_valid", 32'(rsp_vic_valid), 32'(expVv.pop_front()));
          checkOutput("t5_vic_tag", 32'(rsp_vic_tag), 32'(expVt.pop_front()));
        end
      end
      if (k < 12) begin
        req_valid = 1'b1;
        req_fill  = fills[k];
        req_index = idxs[k];
        req_tag   = tags[k];
        if (req_ready) begin
          if (k > 0) checkOutput("t5_accept_spacing", 32'(cyc - lastAcc), lastFill ? 32'd2 : 32'd3);
          if (fills[k]) begin
            model[idxs[k]] = {1'b1, tags[k]};
            expHit.push_back(1'b0);
          end else begin
            lastVv = model[idxs[k]][8];
            lastVt = model[idxs[k]][7:0];
            expHit.push_back(lastVv && (lastVt == tags[k]));
          end
          expVv.push_back(lastVv);
          expVt.push_back(lastVt);
          lastAcc  = cyc;
          lastFill = fills[k];
          k++;
        end
      end else begin
        req_valid = 1'b0;
      end
      cyc++;
      @(negedge clock);
    end
    req_valid = 1'b0;
    checkOutput("t5_all_done", 32'(k == 12 && expHit.size() == 0), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t5_no_extra_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clock);
    end

    $display("[TB] T6 reset during a pending lookup");
    applyStimulus(1'b1, 3'd2, 8'h33);
    expectResponse("t6_fill", 1, 1'b0, lastVv, lastVt);
    applyStimulus(1'b0, 3'd2, 8'h33);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    checkOutput("t6_rst_no_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("t6_rst_init_done", 32'(init_done), 32'd0);
    reset_n = 1'b1;
    sweepCheck("t6_sweep");
    applyStimulus(1'b0, 3'd2, 8'h33);
    expectResponse("t6_miss_after_reset", 2, 1'b0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
